// File: rtl/ln_mean_ctrl.sv
// ln_mean_ctrl: sequencer for the LayerNorm mean unit. It derives inv_n = round(256/N),
// clears and feeds the Ex unit one sample per handshake, then hands the mean to the consumer.
module ln_mean_ctrl #(
    parameter int XW      = 9,
    parameter int MW      = 8,
    parameter int LW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_start,
    input  logic [LW-1:0] i_len,
    input  logic [1:0]    i_alpha,
    output logic          o_busy,
    output logic          o_err,
    input  logic          i_x_valid,
    input  logic [XW-1:0] i_x,
    output logic          o_x_ready,
    output logic          o_ex_rstn,
    output logic          o_ex_valid,
    output logic [XW-1:0] o_ex_x,
    output logic [1:0]    o_ex_alpha,
    output logic [7:0]    o_ex_inv_n,
    input  logic          i_ex_done,
    input  logic [MW-1:0] i_ex,
    output logic          o_mean_valid,
    output logic [MW-1:0] o_mean,
    input  logic          i_mean_ready
);

    localparam int NW = 9;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIV,
        S_CLR,
        S_STREAM,
        S_WAIT,
        S_OUT
    } state_t;

    state_t         state_q;
    logic [LW-1:0]  len_q;
    logic [1:0]     alpha_q;
    logic [LW-1:0]  rem_q;
    logic [NW-1:0]  quo_q;
    logic [3:0]     div_cnt_q;
    logic [7:0]     inv_n_q;
    logic [LW-1:0]  cnt_q;
    logic [TW-1:0]  timer_q;
    logic           busy_q;
    logic           err_q;
    logic           x_ready_q;
    logic           ex_rstn_q;
    logic           ex_valid_q;
    logic [XW-1:0]  ex_x_q;
    logic           mean_valid_q;
    logic [MW-1:0]  mean_q;

    logic [LW:0]    shifted_d;
    logic           fits_d;
    logic [LW-1:0]  rem_d;
    logic [NW-1:0]  quo_d;
    logic [NW-1:0]  numer_d;

    // One restoring-division step: the dividend is shifted MSB-first out of quo_q
    // while quotient bits are shifted in at the bottom.
    always_comb begin
        shifted_d = {rem_q, quo_q[NW-1]};
        fits_d    = (shifted_d >= {1'b0, len_q});
        rem_d     = LW'(fits_d ? (shifted_d - {1'b0, len_q}) : shifted_d);
        quo_d     = {quo_q[NW-2:0], fits_d};
        numer_d   = NW'(256) + NW'(i_len >> 1);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            alpha_q      <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            div_cnt_q    <= '0;
            inv_n_q      <= '0;
            cnt_q        <= '0;
            timer_q      <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            x_ready_q    <= 1'b0;
            ex_rstn_q    <= 1'b0;
            ex_valid_q   <= 1'b0;
            ex_x_q       <= '0;
            mean_valid_q <= 1'b0;
            mean_q       <= '0;
        end else begin
            err_q      <= 1'b0;
            ex_valid_q <= 1'b0;
            ex_rstn_q  <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_len >= LW'(2)) begin
                            len_q     <= i_len;
                            alpha_q   <= i_alpha;
                            quo_q     <= numer_d;
                            rem_q     <= '0;
                            div_cnt_q <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= S_DIV;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_DIV: begin
                    rem_q     <= rem_d;
                    quo_q     <= quo_d;
                    div_cnt_q <= div_cnt_q + 4'd1;
                    if (div_cnt_q == 4'(NW - 1)) begin
                        // quotient never exceeds 128, so the low byte holds it exactly
                        inv_n_q   <= quo_d[7:0];
                        ex_rstn_q <= 1'b0;
                        state_q   <= S_CLR;
                    end
                end
                S_CLR: begin
                    cnt_q   <= '0;
                    state_q <= S_STREAM;
                end
                S_STREAM: begin
                    if (i_x_valid && x_ready_q) begin
                        ex_x_q     <= i_x;
                        ex_valid_q <= 1'b1;
                        cnt_q      <= cnt_q + LW'(1);
                        if ((cnt_q + LW'(1)) == len_q) begin
                            x_ready_q <= 1'b0;
                            timer_q   <= '0;
                            state_q   <= S_WAIT;
                        end
                    end else begin
                        x_ready_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (i_ex_done) begin
                        mean_q       <= i_ex;
                        mean_valid_q <= 1'b1;
                        state_q      <= S_OUT;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_OUT: begin
                    if (i_mean_ready) begin
                        mean_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy       = busy_q;
    assign o_err        = err_q;
    assign o_x_ready    = x_ready_q;
    assign o_ex_rstn    = ex_rstn_q;
    assign o_ex_valid   = ex_valid_q;
    assign o_ex_x       = ex_x_q;
    assign o_ex_alpha   = alpha_q;
    assign o_ex_inv_n   = inv_n_q;
    assign o_mean_valid = mean_valid_q;
    assign o_mean       = mean_q;

endmodule

// File: tb/tb_ln_mean_ctrl.sv
// tb_ln_mean_ctrl: randomized and directed jobs against ln_mean_ctrl, with a behavioural
// Ex-unit model and scoreboards for forwarded samples and returned means.
module tb_ln_mean_ctrl;

    localparam int XW      = 9;
    localparam int MW      = 8;
    localparam int LW      = 8;
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          i_rstn;
    logic          i_start;
    logic [LW-1:0] i_len;
    logic [1:0]    i_alpha;
    logic          o_busy;
    logic          o_err;
    logic          i_x_valid;
    logic [XW-1:0] i_x;
    logic          o_x_ready;
    logic          o_ex_rstn;
    logic          o_ex_valid;
    logic [XW-1:0] o_ex_x;
    logic [1:0]    o_ex_alpha;
    logic [7:0]    o_ex_inv_n;
    logic          i_ex_done;
    logic [MW-1:0] i_ex;
    logic          o_mean_valid;
    logic [MW-1:0] o_mean;
    logic          i_mean_ready;

    int checks = 0;
    int errors = 0;
    int expQ[$];
    int sampleQ[$];
    int vec[$];
    int expErr = 0;
    int errSeen = 0;
    int expInv = 0;
    int expAlpha = 0;
    int exSum = 0;
    int exCnt = 0;
    int curExp = 0;
    bit meanActive = 1'b0;

    ln_mean_ctrl #(.XW(XW), .MW(MW), .LW(LW), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rstn(i_rstn), .i_start(i_start), .i_len(i_len), .i_alpha(i_alpha),
        .o_busy(o_busy), .o_err(o_err), .i_x_valid(i_x_valid), .i_x(i_x), .o_x_ready(o_x_ready),
        .o_ex_rstn(o_ex_rstn), .o_ex_valid(o_ex_valid), .o_ex_x(o_ex_x), .o_ex_alpha(o_ex_alpha),
        .o_ex_inv_n(o_ex_inv_n), .i_ex_done(i_ex_done), .i_ex(i_ex), .o_mean_valid(o_mean_valid),
        .o_mean(o_mean), .i_mean_ready(i_mean_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-half-up mean of an integer sum, using floor division for negative sums.
    function automatic int roundDiv(input int s, input int n);
        int num;
        int den;
        int q;
        num = 2 * s + n;
        den = 2 * n;
        q = num / den;
        if ((num % den != 0) && (num < 0)) q = q - 1;
        return q;
    endfunction

    // Ex-unit model: clears on o_ex_rstn low, accumulates forwarded samples.
    always @(negedge clk) begin : exModel
        int want;
        if (o_ex_rstn === 1'b0) begin
            exSum <= 0;
            exCnt <= 0;
        end else if (o_ex_valid === 1'b1) begin
            exSum <= exSum + int'($signed(o_ex_x));
            exCnt <= exCnt + 1;
            if (sampleQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL ex_x: got unrequested sample %0d, expected none", $signed(o_ex_x));
            end else begin
                want = sampleQ.pop_front();
                checkOutput("ex_x", int'($signed(o_ex_x)), want);
            end
            checkOutput("ex_inv_n", int'(o_ex_inv_n), expInv);
            checkOutput("ex_alpha", int'(o_ex_alpha), expAlpha);
        end
    end

    always @(negedge clk) begin : meanMon
        int want;
        if (o_mean_valid === 1'b1) begin
            want = curExp;
            if (!meanActive) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL mean: got unexpected result %0d, expected none", $signed(o_mean));
                end else begin
                    want = expQ.pop_front();
                end
            end
            checkOutput("mean", int'($signed(o_mean)), want);
            checkOutput("busy_in_out", int'(o_busy), 1);
            curExp <= want;
            meanActive <= !i_mean_ready;
        end else begin
            if (meanActive) begin
                checks++;
                errors++;
                $display("[TB] FAIL mean_valid: got 0 before accept, expected 1");
            end
            meanActive <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (o_err === 1'b1) begin
            errSeen <= errSeen + 1;
            checkOutput("busy_at_err", int'(o_busy), 0);
        end
    end

    task automatic startJob(input int len, input int alpha);
        int c;
        int low;
        expInv = (256 + len / 2) / len;
        expAlpha = alpha;
        i_start = 1'b1;
        i_len = LW'(len);
        i_alpha = 2'(alpha);
        tick();
        i_start = 1'b0;
        checkOutput("busy_after_start", int'(o_busy), 1);
        c = 0;
        low = 0;
        while (o_x_ready !== 1'b1 && c < 40) begin
            tick();
            c++;
            if (o_ex_rstn === 1'b0) low++;
        end
        checkOutput("start_to_ready_cycles", c, 11);
        checkOutput("ex_rstn_low_cycles", low, 1);
        checkOutput("inv_n", int'(o_ex_inv_n), expInv);
        checkOutput("alpha", int'(o_ex_alpha), alpha);
    endtask

    task automatic sendSamples(input int count, input int gapMode, input bit noise, output int sum);
        int i;
        int cyc;
        bit hs;
        i = 0;
        cyc = 0;
        sum = 0;
        while (i < count && cyc < 4000) begin
            case (gapMode)
                0: i_x_valid = 1'b1;
                1: i_x_valid = (cyc % 2 == 0);
                default: i_x_valid = 1'($urandom_range(0, 1));
            endcase
            i_x = XW'(vec[i]);
            if (gapMode == 1 && !i_x_valid) begin
                i_ex_done = 1'b1;
                i_ex = MW'(99);
            end
            if (noise && cyc == 1) begin
                i_start = 1'b1;
                i_len = '0;
                i_alpha = 2'd3;
            end
            hs = i_x_valid && (o_x_ready === 1'b1);
            if (hs) sampleQ.push_back(vec[i]);
            tick();
            i_start = 1'b0;
            i_ex_done = 1'b0;
            if (hs) begin
                sum += vec[i];
                i++;
            end
            cyc++;
        end
        i_x_valid = 1'b0;
        checkOutput("samples_accepted", i, count);
    endtask

    task automatic applyStimulus(input int len, input int alpha, input int gapMode, input bit ramp,
                                 input bit noise, input bit timeoutMode, input int doneDelay,
                                 input int hold);
        int sum;
        int k;
        vec.delete();
        for (int j = 0; j < len; j++) vec.push_back(ramp ? j + 1 : int'($urandom_range(0, 255)) - 128);
        startJob(len, alpha);
        sendSamples(len, gapMode, noise, sum);
        checkOutput("ready_after_last", int'(o_x_ready), 0);
        if (timeoutMode) begin
            k = 0;
            while (o_err !== 1'b1 && k < 200) begin
                tick();
                k++;
            end
            checkOutput("timeout_cycles", k, TIMEOUT);
            expErr++;
            tick();
            checkOutput("busy_after_timeout", int'(o_busy), 0);
            return;
        end
        repeat (doneDelay) tick();
        checkOutput("ex_pulse_count", exCnt, len);
        expQ.push_back(roundDiv(sum, len));
        i_ex_done = 1'b1;
        i_ex = MW'(roundDiv(exSum, len));
        tick();
        i_ex_done = 1'b0;
        checkOutput("mean_valid_rise", int'(o_mean_valid), 1);
        i_mean_ready = 1'b0;
        repeat (hold) tick();
        i_mean_ready = 1'b1;
        tick();
        i_mean_ready = 1'b0;
        checkOutput("mean_valid_fall", int'(o_mean_valid), 0);
        checkOutput("busy_fall", int'(o_busy), 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dummy;
        i_rstn = 1'b0;
        i_start = 1'b0;
        i_len = '0;
        i_alpha = '0;
        i_x_valid = 1'b0;
        i_x = '0;
        i_ex_done = 1'b0;
        i_ex = '0;
        i_mean_ready = 1'b0;
        repeat (3) tick();
        checkOutput("rst_ex_rstn", int'(o_ex_rstn), 0);
        checkOutput("rst_busy", int'(o_busy), 0);
        checkOutput("rst_x_ready", int'(o_x_ready), 0);
        checkOutput("rst_mean_valid", int'(o_mean_valid), 0);
        checkOutput("rst_inv_n", int'(o_ex_inv_n), 0);
        i_rstn = 1'b1;
        tick();
        checkOutput("idle_ex_rstn", int'(o_ex_rstn), 1);

        i_ex_done = 1'b1;
        i_ex = MW'(77);
        repeat (2) tick();
        i_ex_done = 1'b0;
        checkOutput("idle_done_ignored", int'(o_mean_valid), 0);

        for (int n = 0; n < 2; n++) begin
            i_start = 1'b1;
            i_len = LW'(n);
            tick();
            i_start = 1'b0;
            checkOutput("badlen_err", int'(o_err), 1);
            checkOutput("badlen_busy", int'(o_busy), 0);
            expErr++;
            tick();
            checkOutput("badlen_err_pulse", int'(o_err), 0);
        end

        applyStimulus(8, 2, 0, 1'b1, 1'b0, 1'b0, 1, 5);
        applyStimulus(3, 1, 0, 1'b0, 1'b0, 1'b0, 2, 0);
        applyStimulus(2, 0, 0, 1'b0, 1'b0, 1'b0, 1, 1);
        applyStimulus(255, 3, 0, 1'b0, 1'b0, 1'b0, 3, 2);
        applyStimulus(4, 1, 1, 1'b0, 1'b0, 1'b0, 1, 0);
        applyStimulus(6, 2, 0, 1'b0, 1'b1, 1'b0, 2, 1);
        applyStimulus(5, 0, 0, 1'b0, 1'b0, 1'b1, 0, 0);

        vec.delete();
        for (int j = 0; j < 10; j++) vec.push_back(int'($urandom_range(0, 255)) - 128);
        startJob(10, 1);
        sendSamples(3, 0, 1'b0, dummy);
        i_rstn = 1'b0;
        tick();
        checkOutput("midrst_ex_rstn", int'(o_ex_rstn), 0);
        checkOutput("midrst_busy", int'(o_busy), 0);
        checkOutput("midrst_x_ready", int'(o_x_ready), 0);
        sampleQ.delete();
        tick();
        i_rstn = 1'b1;
        tick();
        checkOutput("midrst_release_ex_rstn", int'(o_ex_rstn), 1);
        applyStimulus(7, 3, 0, 1'b0, 1'b0, 1'b0, 1, 0);

        for (int r = 0; r < 6; r++) begin
            applyStimulus(int'($urandom_range(2, 24)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 2)), 1'b0, 1'b0, 1'b0,
                          int'($urandom_range(1, 4)), int'($urandom_range(0, 5)));
        end

        repeat (3) tick();
        checkOutput("err_count", errSeen, expErr);
        checkOutput("mean_queue_left", expQ.size(), 0);
        checkOutput("sample_queue_left", sampleQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
